// File: rtl/wb_clear_arbiter_if.sv
// Writeback arbiter bus: per-producer result handshakes plus the RF write and
// scoreboard clear ports. Producers and the RF side sit on the master modport.
interface wb_clear_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int ID_W    = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_SRC-1:0]             src_v_i;
    logic [NUM_SRC-1:0][ID_W-1:0]   src_id_i;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_data_i;
    logic [NUM_SRC-1:0]             src_ready_o;
    logic                           rf_wb_ready_i;
    logic                           rf_w_v_o;
    logic [ID_W-1:0]                rf_w_addr_o;
    logic [DATA_W-1:0]              rf_w_data_o;
    logic                           clear_o;
    logic [ID_W-1:0]                clear_id_o;
    logic [NUM_SRC-1:0]             pending_o;

    modport slave (
        input  src_v_i, src_id_i, src_data_i, rf_wb_ready_i,
        output src_ready_o, rf_w_v_o, rf_w_addr_o, rf_w_data_o,
               clear_o, clear_id_o, pending_o
    );

    modport master (
        output src_v_i, src_id_i, src_data_i, rf_wb_ready_i,
        input  src_ready_o, rf_w_v_o, rf_w_addr_o, rf_w_data_o,
               clear_o, clear_id_o, pending_o
    );
endinterface

// File: rtl/wb_clear_arbiter.sv
// Writeback end of the register scoreboard: per-producer result FIFOs drained
// round-robin onto one RF write port, with a matching scoreboard clear each grant.
module wb_clear_fifo #(
    parameter int els_p   = 2,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_data_i,
    output logic               enq_ready_o,
    input  logic               deq_i,
    output logic               head_v_o,
    output logic [width_p-1:0] head_data_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                enq, deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at occupancy, so a full FIFO refuses even while draining.
    assign enq_ready_o = (cnt_r != cnt_w_lp'(els_p));
    assign head_v_o    = (cnt_r != '0);
    assign head_data_o = mem_r[rd_ptr_r];
    assign enq         = enq_v_i & enq_ready_o;
    assign deq         = deq_i & head_v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({enq, deq})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= enq_data_i;
    end
endmodule

module wb_clear_arbiter #(
    parameter int els_p             = 32,
    parameter int num_src_p         = 3,
    parameter int data_width_p      = 32,
    parameter int fifo_els_p        = 2,
    parameter int x0_tied_to_zero_p = 0,
    localparam int id_width_lp      = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    wb_clear_arbiter_if.slave bus
);
    localparam int rr_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

    typedef struct packed {
        logic [id_width_lp-1:0]  id;
        logic [data_width_p-1:0] data;
    } entry_s;

    entry_s [num_src_p-1:0] enq_entry, head;
    logic   [num_src_p-1:0] head_v, deq;
    logic   [rr_w_lp-1:0]   rr_ptr_r, grant_idx, cand;
    logic                   grant_v, x0_drop, wr_v;
    int                     idx;

    for (genvar s = 0; s < num_src_p; s++) begin : g_src
        assign enq_entry[s] = '{id: bus.src_id_i[s], data: bus.src_data_i[s]};

        wb_clear_fifo #(
            .els_p   (fifo_els_p),
            .width_p ($bits(entry_s))
        ) fifo (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .enq_v_i     (bus.src_v_i[s]),
            .enq_data_i  (enq_entry[s]),
            .enq_ready_o (bus.src_ready_o[s]),
            .deq_i       (deq[s]),
            .head_v_o    (head_v[s]),
            .head_data_o (head[s])
        );
    end

    // Scan from the farthest offset down so the first pending source at/after rr wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int i = num_src_p - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= num_src_p) idx = idx - num_src_p;
            cand = rr_w_lp'(idx);
            if (head_v[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
        grant_v = grant_v & bus.rf_wb_ready_i;
    end

    always_comb begin
        deq = '0;
        if (grant_v) deq[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            rr_ptr_r <= '0;
        else if (grant_v)
            rr_ptr_r <= (grant_idx == rr_w_lp'(num_src_p - 1)) ? '0 : grant_idx + 1'b1;
    end

    // A granted x0 result is still consumed, it just never reaches the RF or scoreboard.
    assign x0_drop = (x0_tied_to_zero_p != 0) && (head[grant_idx].id == '0);
    assign wr_v    = grant_v & ~x0_drop;

    assign bus.rf_w_v_o    = wr_v;
    assign bus.clear_o     = wr_v;
    assign bus.rf_w_addr_o = head[grant_idx].id;
    assign bus.clear_id_o  = head[grant_idx].id;
    assign bus.rf_w_data_o = head[grant_idx].data;
    assign bus.pending_o   = head_v;

`ifndef SYNTHESIS
    // The scoreboard blocks WAW, so two live heads targeting one register is a protocol bug.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < num_src_p; i++)
                for (int j = i + 1; j < num_src_p; j++)
                    assert (!(head_v[i] && head_v[j] && head[i].id == head[j].id))
                        else $error("wb_clear_arbiter: sources %0d and %0d hold id %0d", i, j, head[i].id);
        end
    end
`endif
endmodule

// File: tb/tb_wb_clear_arbiter.sv
// Self-checking bench for wb_clear_arbiter: directed scenarios plus a randomized
// scoreboard loopback checked against a queue-based reference model.
module tb_wb_clear_arbiter;
    localparam int N   = 3;
    localparam int IDW = 5;
    localparam int DW  = 32;
    localparam int FE  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } ent_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ent_t mq[N][$];
    int   mrr;

    wb_clear_arbiter_if #(.NUM_SRC(N), .ID_W(IDW), .DATA_W(DW)) ifa ();
    wb_clear_arbiter_if #(.NUM_SRC(N), .ID_W(IDW), .DATA_W(DW)) ifb ();

    wb_clear_arbiter #(.els_p(32), .num_src_p(N), .data_width_p(DW), .fifo_els_p(FE),
                       .x0_tied_to_zero_p(0)) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa.slave));
    wb_clear_arbiter #(.els_p(32), .num_src_p(N), .data_width_p(DW), .fifo_els_p(FE),
                       .x0_tied_to_zero_p(1)) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First pending source at or after the rr pointer, or -1 when nothing is granted.
    function automatic int model_grant(input logic rdy);
        if (!rdy) return -1;
        for (int k = 0; k < N; k++) begin
            int s = (mrr + k) % N;
            if (mq[s].size() != 0) return s;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        ifa.src_v_i = '0; ifa.src_id_i = '0; ifa.src_data_i = '0; ifa.rf_wb_ready_i = 1'b0;
        ifb.src_v_i = '0; ifb.src_id_i = '0; ifb.src_data_i = '0; ifb.rf_wb_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < N; s++) mq[s].delete();
        mrr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (ifa.pending_o !== 3'b000)   begin n_err++; $display("FAIL reset_pending got=%b exp=000", ifa.pending_o); end
        n_cmp++; if (ifa.rf_w_v_o !== 1'b0)      begin n_err++; $display("FAIL reset_wv got=%b exp=0", ifa.rf_w_v_o); end
        n_cmp++; if (ifa.clear_o !== 1'b0)       begin n_err++; $display("FAIL reset_clear got=%b exp=0", ifa.clear_o); end
        n_cmp++; if (ifa.src_ready_o !== 3'b111) begin n_err++; $display("FAIL reset_ready got=%b exp=111", ifa.src_ready_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        ifa.src_v_i = 3'b010; ifa.src_id_i[1] = 5'd5; ifa.src_data_i[1] = 32'hDEAD;
        ifa.rf_wb_ready_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifa.rf_w_v_o !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", ifa.rf_w_v_o); end
        @(posedge clk); #1;
        ifa.src_v_i = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.rf_w_v_o !== 1'b1 || ifa.rf_w_addr_o !== 5'd5 || ifa.rf_w_data_o !== 32'hDEAD ||
            ifa.clear_o !== 1'b1 || ifa.clear_id_o !== 5'd5) begin
            n_err++;
            $display("FAIL single_write got v=%b a=%0d d=%h c=%b cid=%0d exp v=1 a=5 d=dead c=1 cid=5",
                     ifa.rf_w_v_o, ifa.rf_w_addr_o, ifa.rf_w_data_o, ifa.clear_o, ifa.clear_id_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (ifa.rf_w_v_o !== 1'b0 || ifa.clear_o !== 1'b0 || ifa.pending_o !== 3'b000) begin
            n_err++;
            $display("FAIL single_once got v=%b c=%b p=%b exp v=0 c=0 p=000", ifa.rf_w_v_o, ifa.clear_o, ifa.pending_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        do_reset();
        ifa.rf_wb_ready_i = 1'b1;
        ifa.src_v_i = 3'b111;
        for (int s = 0; s < N; s++) begin
            ifa.src_id_i[s] = IDW'(s + 1); ifa.src_data_i[s] = 32'hA000_0000 | (s + 1);
        end
        @(posedge clk); #1;
        for (int s = 0; s < N; s++) begin
            ifa.src_id_i[s] = IDW'(s + 11); ifa.src_data_i[s] = 32'hA000_0000 | (s + 11);
        end
        for (int i = 0; i < 6; i++) begin
            int g, eid;
            g   = i % N;
            eid = (i < 3) ? g + 1 : g + 11;
            @(negedge clk);
            n_cmp++;
            if (ifa.rf_w_v_o !== 1'b1 || ifa.rf_w_addr_o !== IDW'(eid) || ifa.clear_id_o !== IDW'(eid) ||
                ifa.rf_w_data_o !== (32'hA000_0000 | eid)) begin
                n_err++;
                $display("FAIL fair_order slot=%0d got v=%b a=%0d d=%h exp v=1 a=%0d", i,
                         ifa.rf_w_v_o, ifa.rf_w_addr_o, ifa.rf_w_data_o, eid);
            end
            @(posedge clk); #1;
            ifa.src_v_i = '0;
        end
        @(negedge clk);
        n_cmp++; if (ifa.rf_w_v_o !== 1'b0) begin n_err++; $display("FAIL fair_idle got=%b exp=0", ifa.rf_w_v_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        ifa.rf_wb_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ifa.src_v_i = 3'b001; ifa.src_id_i[0] = IDW'(20 + c); ifa.src_data_i[0] = 32'h2000 + c;
            @(negedge clk);
            n_cmp++;
            if (ifa.src_ready_o[0] !== (acc < FE) || ifa.rf_w_v_o !== 1'b0 || ifa.clear_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b c=%b exp rdy=%b v=0 c=0", c,
                         ifa.src_ready_o[0], ifa.rf_w_v_o, ifa.clear_o, acc < FE);
            end
            if (acc < FE) acc++;
            @(posedge clk); #1;
        end
        ifa.src_v_i = '0; ifa.rf_wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 2) begin
                if (ifa.rf_w_v_o !== 1'b1 || ifa.rf_w_addr_o !== IDW'(20 + k) || ifa.rf_w_data_o !== 32'h2000 + k) begin
                    n_err++;
                    $display("FAIL bp_drain k=%0d got v=%b a=%0d d=%h exp v=1 a=%0d", k,
                             ifa.rf_w_v_o, ifa.rf_w_addr_o, ifa.rf_w_data_o, 20 + k);
                end
            end else if (ifa.rf_w_v_o !== 1'b0) begin
                n_err++; $display("FAIL bp_empty got=%b exp=0", ifa.rf_w_v_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        ifb.rf_wb_ready_i = 1'b1;
        ifb.src_v_i = 3'b100; ifb.src_id_i[2] = 5'd0; ifb.src_data_i[2] = 32'h11;
        @(posedge clk); #1;
        ifb.src_id_i[2] = 5'd7; ifb.src_data_i[2] = 32'h77;
        @(negedge clk);
        n_cmp++;
        if (ifb.rf_w_v_o !== 1'b0 || ifb.clear_o !== 1'b0 || ifb.pending_o[2] !== 1'b1) begin
            n_err++;
            $display("FAIL x0_drop got v=%b c=%b p2=%b exp v=0 c=0 p2=1", ifb.rf_w_v_o, ifb.clear_o, ifb.pending_o[2]);
        end
        @(posedge clk); #1;
        ifb.src_v_i = '0;
        @(negedge clk);
        n_cmp++;
        if (ifb.rf_w_v_o !== 1'b1 || ifb.rf_w_addr_o !== 5'd7 || ifb.rf_w_data_o !== 32'h77 ||
            ifb.clear_o !== 1'b1 || ifb.clear_id_o !== 5'd7 || ifb.pending_o[2] !== 1'b1) begin
            n_err++;
            $display("FAIL x0_id7 got v=%b a=%0d c=%b cid=%0d exp v=1 a=7 c=1 cid=7",
                     ifb.rf_w_v_o, ifb.rf_w_addr_o, ifb.clear_o, ifb.clear_id_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (ifb.rf_w_v_o !== 1'b0 || ifb.pending_o[2] !== 1'b0) begin
            n_err++; $display("FAIL x0_done got v=%b p2=%b exp v=0 p2=0", ifb.rf_w_v_o, ifb.pending_o[2]);
        end
        @(posedge clk); #1;
        ifb.rf_wb_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        // rr currently points at src1 after the src0-only drain.
        ifa.rf_wb_ready_i = 1'b0;
        ifa.src_v_i = 3'b110; ifa.src_id_i[1] = 5'd30; ifa.src_id_i[2] = 5'd32;
        @(posedge clk); #1;
        ifa.src_v_i = 3'b010; ifa.src_id_i[1] = 5'd31;
        @(posedge clk); #1;
        ifa.src_v_i = '0; ifa.rf_wb_ready_i = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifa.pending_o !== 3'b000 || ifa.rf_w_v_o !== 1'b0 || ifa.src_ready_o !== 3'b111) begin
            n_err++;
            $display("FAIL rmid_flush got p=%b v=%b r=%b exp p=000 v=0 r=111", ifa.pending_o, ifa.rf_w_v_o, ifa.src_ready_o);
        end
        @(posedge clk); #1;
        ifa.src_v_i = 3'b101; ifa.src_id_i[0] = 5'd40; ifa.src_id_i[2] = 5'd42;
        ifa.src_data_i[0] = 32'h40; ifa.src_data_i[2] = 32'h42;
        @(negedge clk);
        n_cmp++; if (ifa.rf_w_v_o !== 1'b0) begin n_err++; $display("FAIL rmid_nowrite got=%b exp=0", ifa.rf_w_v_o); end
        @(posedge clk); #1;
        ifa.src_v_i = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.rf_w_v_o !== 1'b1 || ifa.rf_w_addr_o !== 5'd40) begin
            n_err++; $display("FAIL rmid_rr0 got v=%b a=%0d exp v=1 a=40", ifa.rf_w_v_o, ifa.rf_w_addr_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (ifa.rf_w_v_o !== 1'b1 || ifa.rf_w_addr_o !== 5'd42) begin
            n_err++; $display("FAIL rmid_next got v=%b a=%0d exp v=1 a=42", ifa.rf_w_v_o, ifa.rf_w_addr_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loopback();
        bit             scored [32];
        bit             hold   [N];
        logic [IDW-1:0] hid    [N];
        logic [DW-1:0]  hdat   [N];
        int             pre    [N];
        logic [N-1:0]   exp_p, exp_r;
        int             g, r, left;
        bit             exp_wv;
        ent_t           e;
        do_reset();
        for (int i = 0; i < 32; i++) scored[i] = 1'b0;
        for (int s = 0; s < N; s++) begin hold[s] = 1'b0; hid[s] = '0; hdat[s] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int s = 0; s < N; s++) begin
                if (!hold[s] && cyc < 340 && $urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 31);
                    if (!scored[r]) begin
                        scored[r] = 1'b1; hold[s] = 1'b1; hid[s] = IDW'(r); hdat[s] = $urandom;
                    end
                end
                ifa.src_v_i[s] = hold[s]; ifa.src_id_i[s] = hid[s]; ifa.src_data_i[s] = hdat[s];
            end
            ifa.rf_wb_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g      = model_grant(ifa.rf_wb_ready_i);
            exp_wv = (g >= 0);
            for (int s = 0; s < N; s++) begin
                exp_p[s] = (mq[s].size() != 0);
                exp_r[s] = (mq[s].size() < FE);
            end
            n_cmp++;
            if (ifa.rf_w_v_o !== exp_wv || ifa.clear_o !== exp_wv) begin
                n_err++; $display("FAIL loop_valid cyc=%0d got v=%b c=%b exp=%b", cyc, ifa.rf_w_v_o, ifa.clear_o, exp_wv);
            end
            n_cmp++;
            if (ifa.pending_o !== exp_p || ifa.src_ready_o !== exp_r) begin
                n_err++; $display("FAIL loop_state cyc=%0d got p=%b r=%b exp p=%b r=%b", cyc,
                                  ifa.pending_o, ifa.src_ready_o, exp_p, exp_r);
            end
            if (g >= 0) begin
                e = mq[g][0];
                n_cmp++;
                if (ifa.rf_w_addr_o !== e.id || ifa.clear_id_o !== e.id || ifa.rf_w_data_o !== e.data) begin
                    n_err++; $display("FAIL loop_data cyc=%0d got a=%0d cid=%0d d=%h exp a=%0d d=%h", cyc,
                                      ifa.rf_w_addr_o, ifa.clear_id_o, ifa.rf_w_data_o, e.id, e.data);
                end
            end
            @(posedge clk);
            for (int s = 0; s < N; s++) pre[s] = mq[s].size();
            if (g >= 0) begin
                scored[mq[g][0].id] = 1'b0;
                void'(mq[g].pop_front());
                mrr = (g + 1) % N;
            end
            for (int s = 0; s < N; s++) begin
                if (hold[s] && pre[s] < FE) begin
                    e.id = hid[s]; e.data = hdat[s];
                    mq[s].push_back(e);
                    hold[s] = 1'b0;
                end
            end
            #1;
        end
        left = 0;
        for (int i = 0; i < 32; i++) if (scored[i]) left++;
        n_cmp++;
        if (left != 0) begin n_err++; $display("FAIL loop_uncleared got=%0d exp=0", left); end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mrr   = 0;
        rst   = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_x0();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
